// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and sizing for the decoder scan sequencer and its helpers.
package scan_pkg;

  localparam int SCAN_N     = 4;
  localparam int SCAN_LINES = 2 ** SCAN_N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_DWELL,
    ST_BLANK
  } scan_state_t;

endpackage

// File: rtl/decoder_scan_sequencer_mask_priority_search.sv
// Combinational search for the lowest set mask bit at or above a start pointer.
// A pointer of 2**N (one past the top line) always reports not found.
module mask_priority_search #(
  parameter int N = 4
) (
  input  logic [2**N-1:0] mask,
  input  logic [N:0]      ptr,
  output logic            found,
  output logic [N-1:0]    index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    // Descending scan so the lowest qualifying index is the last one written.
    for (int i = 2**N - 1; i >= 0; i--) begin
      if (mask[i] && ((N+1)'(i) >= ptr)) begin
        found = 1'b1;
        index = N'(i);
      end
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Walks a 4-to-16 decoder one enabled line at a time: dwell+1 cycles with en
// high per line, then BLANK+1 cycles with en low before the next line.
//
// Handshake: start is a one-cycle request accepted only in IDLE with a
// non-zero line_mask; stop aborts from any state and wins over start.
module decoder_scan_sequencer
  import scan_pkg::*;
#(
  parameter int N     = SCAN_N,
  parameter int DIV_W = 16,
  parameter int BLANK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [DIV_W-1:0] dwell,
  input  logic [2**N-1:0]  line_mask,
  output logic [N-1:0]     sel,
  output logic             en,
  output logic             busy,
  output logic             line_done,
  output logic             frame_done,
  output logic [1:0]       dbg_state
);

  localparam logic [DIV_W-1:0] BLANK_LAST = (BLANK > 0) ? DIV_W'(BLANK - 1) : '0;

  scan_state_t      state;
  logic [2**N-1:0]  mask_q;
  logic [DIV_W-1:0] dwell_q;
  logic [DIV_W-1:0] cnt;
  logic             cont_q;
  logic             last_q;
  logic [N:0]       ptr;
  logic             found;
  logic [N-1:0]     idx;
  logic             relatch;

  assign dbg_state = state;
  assign relatch   = cont_q && (line_mask != '0);

  // While a line dwells, ptr already points past it, so !found means this
  // line is the last enabled one of the frame.
  mask_priority_search #(.N(N)) u_search (
    .mask  (mask_q),
    .ptr   (ptr),
    .found (found),
    .index (idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      mask_q     <= '0;
      dwell_q    <= '0;
      cont_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        sel   <= '0;
        en    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && (line_mask != '0)) begin
              mask_q  <= line_mask;
              dwell_q <= dwell;
              cont_q  <= continuous;
              ptr     <= '0;
              busy    <= 1'b1;
              state   <= ST_SEEK;
            end
          end
          ST_SEEK: begin
            if (found) begin
              sel   <= idx;
              ptr   <= {1'b0, idx} + (N+1)'(1);
              cnt   <= '0;
              en    <= 1'b1;
              state <= ST_DWELL;
            end else begin
              frame_done <= 1'b1;
              if (relatch) begin
                mask_q <= line_mask;
                ptr    <= '0;
              end else begin
                state <= ST_IDLE;
                sel   <= '0;
                busy  <= 1'b0;
              end
            end
          end
          ST_DWELL: begin
            if (cnt == dwell_q) begin
              en         <= 1'b0;
              line_done  <= 1'b1;
              frame_done <= !found;
              last_q     <= !found;
              cnt        <= '0;
              if (BLANK > 0) begin
                state <= ST_BLANK;
              end else if (found) begin
                state <= ST_SEEK;
              end else if (relatch) begin
                mask_q <= line_mask;
                ptr    <= '0;
                state  <= ST_SEEK;
              end else begin
                state <= ST_IDLE;
                sel   <= '0;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
              if (!last_q) begin
                state <= ST_SEEK;
              end else if (relatch) begin
                mask_q <= line_mask;
                ptr    <= '0;
                state  <= ST_SEEK;
              end else begin
                state <= ST_IDLE;
                sel   <= '0;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: BLANK=2 and BLANK=0 instances share one
// input stream and are compared every cycle against a per-line timeline model.
module tb_decoder_scan_sequencer;

  localparam int MAXT = 75000;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stop, continuous;
  logic [15:0] dwell, line_mask;

  logic [3:0] sel2, sel0;
  logic       en2, busy2, ld2, fd2, en0, busy0, ld0, fd0;
  logic [1:0] dbg2, dbg0;

  decoder_scan_sequencer #(.N(4), .DIV_W(16), .BLANK(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .line_mask(line_mask), .sel(sel2), .en(en2), .busy(busy2),
    .line_done(ld2), .frame_done(fd2), .dbg_state(dbg2)
  );

  decoder_scan_sequencer #(.N(4), .DIV_W(16), .BLANK(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .line_mask(line_mask), .sel(sel0), .en(en0), .busy(busy0),
    .line_done(ld0), .frame_done(fd0), .dbg_state(dbg0)
  );

  // stimulus tables, one entry per clock edge
  logic        st_a[MAXT], sp_a[MAXT], ct_a[MAXT], rs_a[MAXT];
  logic [15:0] dw_a[MAXT], mk_a[MAXT];
  logic [7:0]  mdl[MAXT];
  int          p;
  logic [15:0] c_mask, c_dwell;
  logic        c_cont;
  int          sc1_t, sc2_t, sc3_t, sc4_t, sc5_t;

  // scoreboard
  logic [7:0] exp2_q[$];
  logic [7:0] exp0_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic void cyc(logic s, logic sp, logic r);
    st_a[p] = s; sp_a[p] = sp; rs_a[p] = r;
    ct_a[p] = c_cont; dw_a[p] = c_dwell; mk_a[p] = c_mask;
    p++;
  endfunction

  function automatic void idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [7:0] pk(int s, logic e, logic b, logic l, logic f);
    return {s[3:0], e, b, l, f};
  endfunction

  // Timeline model: each accepted start gives one SEEK cycle, then per enabled
  // line dwell+1 en-high cycles and b+1 en-low cycles; the last low cycle of a
  // frame either re-enters the next frame or returns to idle.
  function automatic void run_model(int b);
    int t, d, last_i;
    logic [15:0] m, nm;
    logic c, active, wrap, ld, fd;
    t = 0;
    while (t < p) begin
      if (rs_a[t] || sp_a[t] || !st_a[t] || mk_a[t] == 16'h0) begin
        mdl[t] = 8'h00;
        t++;
      end else begin
        m = mk_a[t]; d = int'(dw_a[t]); c = ct_a[t];
        mdl[t] = pk(0, 1'b0, 1'b1, 1'b0, 1'b0);
        t++;
        active = 1'b1;
        while (active) begin
          last_i = 0;
          for (int i = 0; i < 16; i++) if (m[i]) last_i = i;
          wrap = 1'b0;
          nm = m;
          for (int i = 0; i < 16; i++) begin
            if (active && m[i]) begin
              for (int k = 0; k <= d; k++) begin
                if (active) begin
                  if (t >= p) active = 1'b0;
                  else if (rs_a[t] || sp_a[t]) begin mdl[t] = 8'h00; t++; active = 1'b0; end
                  else begin mdl[t] = pk(i, 1'b1, 1'b1, 1'b0, 1'b0); t++; end
                end
              end
              for (int g = 1; g <= b + 1; g++) begin
                if (active) begin
                  ld = (g == 1);
                  fd = ld && (i == last_i);
                  if (t >= p) active = 1'b0;
                  else if (rs_a[t] || sp_a[t]) begin mdl[t] = 8'h00; t++; active = 1'b0; end
                  else begin
                    if (g == b + 1 && i == last_i) begin
                      if (c && mk_a[t] != 16'h0) begin
                        mdl[t] = pk(i, 1'b0, 1'b1, ld, fd); nm = mk_a[t]; wrap = 1'b1;
                      end else begin
                        mdl[t] = pk(0, 1'b0, 1'b0, ld, fd); active = 1'b0;
                      end
                    end else begin
                      mdl[t] = pk(i, 1'b0, 1'b1, ld, fd);
                    end
                    t++;
                  end
                end
              end
            end
          end
          if (wrap && active) m = nm;
          else active = 1'b0;
        end
      end
    end
  endfunction

  function automatic int tally(int a, int z, int bit_idx);
    int n = 0;
    for (int t = a; t < z; t++) if (mdl[t][bit_idx]) n++;
    return n;
  endfunction

  task automatic check_eq(string name, int got, int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Hand-derived expectations that pin the model itself.
  task automatic pin_model(int b);
    int n01, n8;
    check_eq($sformatf("b%0d reset_out", b), int'(mdl[2]), 0);
    check_eq($sformatf("b%0d seek_cycle", b), int'(mdl[sc1_t]), int'(pk(0, 1'b0, 1'b1, 1'b0, 1'b0)));
    check_eq($sformatf("b%0d first_en", b), int'(mdl[sc1_t + 1]), int'(pk(0, 1'b1, 1'b1, 1'b0, 1'b0)));
    check_eq($sformatf("b%0d full_en", b), tally(sc1_t, sc2_t, 3), 64);
    check_eq($sformatf("b%0d full_ld", b), tally(sc1_t, sc2_t, 1), 16);
    check_eq($sformatf("b%0d full_fd", b), tally(sc1_t, sc2_t, 0), 1);
    check_eq($sformatf("b%0d sparse_en", b), tally(sc2_t, sc3_t, 3), 4);
    check_eq($sformatf("b%0d sparse_ld", b), tally(sc2_t, sc3_t, 1), 4);
    check_eq($sformatf("b%0d sparse_fd", b), tally(sc2_t, sc3_t, 0), 1);
    n01 = 0; n8 = 0;
    for (int t = sc3_t; t < sc4_t; t++) begin
      if (mdl[t][3] && mdl[t][7:4] <= 4'd1) n01++;
      if (mdl[t][3] && mdl[t][7:4] == 4'd8) n8++;
    end
    check_eq($sformatf("b%0d cont_first_frame", b), n01, 6);
    check_eq($sformatf("b%0d cont_line8_seen", b), int'(n8 > 0), 1);
    check_eq($sformatf("b%0d long_en", b), tally(sc5_t, p, 3), 65536);
    check_eq($sformatf("b%0d long_fd", b), tally(sc5_t, p, 0), 1);
  endtask

  task automatic compare(int k);
    logic [7:0] g2, g0, e2, e0;
    g2 = {sel2, en2, busy2, ld2, fd2};
    g0 = {sel0, en0, busy0, ld0, fd0};
    e2 = exp2_q.pop_front();
    e0 = exp0_q.pop_front();
    n_checks += 2;
    if (g2 !== e2) begin
      n_errors++;
      if (n_errors < 20)
        $display("FAIL out_blank2 cyc %0d: got sel=%0d en=%b busy=%b ld=%b fd=%b, expected sel=%0d en=%b busy=%b ld=%b fd=%b",
                 k, g2[7:4], g2[3], g2[2], g2[1], g2[0], e2[7:4], e2[3], e2[2], e2[1], e2[0]);
    end
    if (g0 !== e0) begin
      n_errors++;
      if (n_errors < 20)
        $display("FAIL out_blank0 cyc %0d: got sel=%0d en=%b busy=%b ld=%b fd=%b, expected sel=%0d en=%b busy=%b ld=%b fd=%b",
                 k, g0[7:4], g0[3], g0[2], g0[1], g0[0], e0[7:4], e0[3], e0[2], e0[1], e0[0]);
    end
  endtask

  task automatic build_stimulus();
    int r;
    p = 0;
    c_mask = 16'hFFFF; c_dwell = 16'd3; c_cont = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
    // full frame, with an ignored start while busy
    sc1_t = p;
    cyc(1'b1, 1'b0, 1'b0);
    idle(20);
    c_mask = 16'h1234; cyc(1'b1, 1'b0, 1'b0);
    idle(120);
    // sparse mask
    sc2_t = p;
    c_mask = 16'h8421; c_dwell = 16'd0;
    cyc(1'b1, 1'b0, 1'b0);
    idle(30);
    // continuous with a mask change mid-frame
    sc3_t = p;
    c_mask = 16'h0003; c_dwell = 16'd2; c_cont = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    idle(4);
    c_mask = 16'h0100;
    idle(60);
    cyc(1'b0, 1'b1, 1'b0);
    idle(5);
    // abort during line 6, empty-mask start, start+stop together
    sc4_t = p;
    c_mask = 16'hFFFF; c_dwell = 16'd5; c_cont = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    idle(57);
    cyc(1'b0, 1'b1, 1'b0);
    idle(5);
    c_mask = 16'h0000; cyc(1'b1, 1'b0, 1'b0); idle(5);
    c_mask = 16'hFFFF; cyc(1'b1, 1'b1, 1'b0); idle(5);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        r = $urandom_range(0, 3);
        if (r == 0) c_mask = 16'h0;
        else if (r == 1) c_mask = 16'h1 << $urandom_range(0, 15);
        else c_mask = 16'($urandom());
      end
      if ($urandom_range(0, 9) == 0) c_dwell = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) c_cont = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 14) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 399) == 0);
    end
    cyc(1'b0, 1'b1, 1'b0);
    idle(3);
    // maximum dwell
    sc5_t = p;
    c_mask = 16'h0001; c_dwell = 16'hFFFF; c_cont = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    idle(65545);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    dwell = '0; line_mask = '0;
    build_stimulus();
    run_model(2);
    pin_model(2);
    for (int t = 0; t < p; t++) exp2_q.push_back(mdl[t]);
    run_model(0);
    pin_model(0);
    for (int t = 0; t < p; t++) exp0_q.push_back(mdl[t]);

    // driver loop: apply inputs, let the edge sample them, compare mid-cycle
    for (int k = 0; k < p; k++) begin
      reset = rs_a[k]; start = st_a[k]; stop = sp_a[k];
      continuous = ct_a[k]; dwell = dw_a[k]; line_mask = mk_a[k];
      @(posedge clk);
      @(negedge clk);
      compare(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 4-to-16 binary decoder: generates the registered `sel`/`en` pair that walks the decoder outputs one line at a time.
- Skips masked lines, holds each line for a programmable dwell, and inserts a blanking gap between lines.
- Used for multiplexed displays and keypad row scanning; `sel`/`en` connect directly to the decoder's `sel`/`en` inputs.

Parameters:
- N, 4: select width; number of lines = 2**N.
- DIV_W, 16: width of the dwell-count input.
- BLANK, 2: extra en-low cycles after each line (0 allowed).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin scanning; ignored while busy.
- stop  in  1  synchronous abort; has priority over everything except reset.
- continuous  in  1  sampled at start; 1 = repeat frames until stop, 0 = single frame.
- dwell  in  DIV_W  en-high length per line = dwell+1 cycles; sampled at start.
- line_mask  in  2**N  bit i=1 enables line i; sampled at start and at each frame wrap.
- sel  out  N  registered line index to the decoder.
- en  out  1  registered decoder enable.
- busy  out  1  high in any state other than IDLE.
- line_done  out  1  one-cycle pulse, first cycle after a line's en-high period.
- frame_done  out  1  one-cycle pulse when the last enabled line of a frame completes.

Behaviour:
- Reset: state=IDLE; sel=0, en=0, busy=0, line_done=0, frame_done=0; internal pointer, dwell counter and latched mask cleared.
- All outputs are registered; no combinational input-to-output paths.
- IDLE:
  - start=1 with line_mask!=0 → latch mask, dwell and continuous; pointer=0; go to SEEK.
  - start=1 with line_mask==0 → ignored; stay IDLE, no pulses.
- SEEK (1 cycle, en=0):
  - Priority-search the latched mask for the lowest enabled index >= pointer.
  - Found → load sel with that index, clear dwell counter, go to DWELL.
  - Not found → end of frame (see below).
- DWELL:
  - en=1, sel held; counter increments each cycle.
  - When counter==dwell → next cycle BLANK, en=0, line_done=1.
- BLANK:
  - en=0, sel held for BLANK cycles; then pointer=sel+1, go to SEEK.
  - With BLANK=0, go directly from DWELL to SEEK.
  - If sel==2**N-1, the pointer wrap is an end of frame.
- End of frame:
  - frame_done pulses coincident with the final line's line_done cycle when the frame end is known at that point (sel is the highest enabled index); otherwise it pulses in the SEEK cycle that finds no line.
  - continuous=1 → re-latch line_mask; pointer=0; SEEK. A newly sampled all-zero mask → IDLE.
  - continuous=0 → IDLE.
- Timing:
  - start sampled at edge t → SEEK during cycle t+1 → en=1 from edge t+2.
  - en is high for exactly dwell+1 cycles per line.
  - en is low for exactly BLANK+1 cycles between consecutive lines of a frame.
- stop: from any state, next edge → IDLE, en=0, busy=0, sel=0; no line_done or frame_done is generated by the abort.
- start while busy: ignored. start and stop in the same cycle: stop wins.
- Single enabled line in continuous mode: the line repeats with frame_done on every repetition.
- Reset mid-scan: same as the reset values above, on the next edge.
- Width rules:
  - pointer is N+1 bits so the wrap past 2**N-1 is detectable.
  - The dwell counter is DIV_W bits; dwell=all-ones is legal and gives 2**DIV_W cycles.

Decomposition:
- Package scan_pkg holds the state enum typedef (IDLE, SEEK, DWELL, BLANK) and a localparam for the line count.
- One natural sub-module, mask_priority_search: combinational. Inputs are the mask and the start pointer; outputs are found and index. It is reusable by the downstream priority encoder work.

Test Plan:
- Reset check: assert reset with start=1 → sel=0, en=0, busy=0, both pulses 0.
- Single frame: mask=16'hFFFF, dwell=3, BLANK=2, continuous=0, start pulse → sel 0..15 in order, each with en high 4 cycles and low 3 cycles. frame_done pulses once with sel=15's line_done. Then busy=0.
- Sparse mask: mask=16'h8421, dwell=0 → lines 0,5,10,15 only, each with en high 1 cycle; exactly 4 line_done pulses and 1 frame_done.
- Continuous wrap with mask change: mask=16'h0003, continuous=1; change mask to 16'h0100 mid-frame → the current frame finishes lines 0,1; the next frame scans only line 8.
- Abort and ignore: stop during DWELL of line 6 → en=0 and busy=0 next cycle with no line_done. Separately, start while busy has no effect, and start with mask=0 leaves busy=0.
- Edge values: dwell=16'hFFFF on mask=16'h0001 → en high exactly 65536 cycles. Repeat with parameter BLANK=0 → en low exactly 1 cycle between lines.
